// File: rtl/gcm_frame_pkg.sv
// ============================================================================
//  Module      : gcm_frame_pkg
//  Description : Shared constants for the GCM frame aligner: FSM state
//                encoding, the default frame alignment signal (FAS) and a
//                helper that sizes the hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gcm_frame_pkg;

  // Aligner FSM states.
  localparam logic [1:0] c_hunt    = 2'd0;
  localparam logic [1:0] c_presync = 2'd1;
  localparam logic [1:0] c_sync    = 2'd2;

  // FAS pattern normally carried at the start of every frame.
  localparam logic [47:0] c_default_fas = 48'hf6f6f6282828;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gcm_fas_match.sv
// ============================================================================
//  Module      : gcm_fas_match
//  Description : Combinational FAS comparator. Selects the NB_FAS-bit field
//                holding the FAS (MSB end when MSB_IS_NEWER=0, LSB end when
//                MSB_IS_NEWER=1) in both the stream word and the template
//                and flags equality.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcm_fas_match #(
  parameter int NB_DATA      = 256,
  parameter int NB_FAS       = 48,
  parameter int MSB_IS_NEWER = 0
) (
  input  logic [NB_DATA-1:0] i_data,
  input  logic [NB_DATA-1:0] i_fas,
  output logic               o_hit
);

  // Bits outside the FAS field never take part in the comparison.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_data, i_fas};

  generate
    if (MSB_IS_NEWER == 0) begin : g_msb_field
      assign o_hit = (i_data[NB_DATA-1 -: NB_FAS] == i_fas[NB_DATA-1 -: NB_FAS]);
    end else begin : g_lsb_field
      assign o_hit = (i_data[NB_FAS-1:0] == i_fas[NB_FAS-1:0]);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/gcm_frame_aligner.sv
// ============================================================================
//  Module      : gcm_frame_aligner
//  Description : Word-granular frame aligner. Hunts for the FAS, confirms it
//                over N_CONFIRM further frames, declares lock and then emits
//                a start-of-packet pulse on every frame's first word. Lock is
//                dropped after N_LOSS consecutive FAS misses. All outputs are
//                registered (one cycle latency).
//                Optional build macro GCM_FRAME_ALIGNER_FAS_ERR_CNT_EN adds a
//                saturating counter of FAS misses seen while locked.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcm_frame_aligner
  import gcm_frame_pkg::*;
#(
  parameter int NB_DATA       = 256,
  parameter int NB_FRAME_SIZE = 16,
  parameter int NB_FAS        = 48,
  parameter int MSB_IS_NEWER  = 0,
  parameter int N_CONFIRM     = 2,
  parameter int N_LOSS        = 3
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NB_DATA-1:0]       i_data,
  input  logic                     i_valid,
  input  logic [NB_FRAME_SIZE-1:0] i_frame_size,
  input  logic [NB_DATA-1:0]       i_fas,
  output logic [NB_DATA-1:0]       o_data,
  output logic                     o_valid,
  output logic                     o_sop,
  output logic                     o_lock,
  output logic [15:0]              o_fas_err_count
);

  localparam int c_hit_w  = cnt_width(N_CONFIRM);
  localparam int c_miss_w = cnt_width(N_LOSS);

  logic w_hit;

  gcm_fas_match #(
    .NB_DATA      (NB_DATA),
    .NB_FAS       (NB_FAS),
    .MSB_IS_NEWER (MSB_IS_NEWER)
  ) u_fas_match (
    .i_data (i_data),
    .i_fas  (i_fas),
    .o_hit  (w_hit)
  );

  logic [1:0]               r_state,    w_state_nxt;
  logic [NB_FRAME_SIZE-1:0] r_word_cnt, w_word_cnt_nxt;
  logic [c_hit_w-1:0]       r_hit_cnt,  w_hit_cnt_nxt;
  logic [c_miss_w-1:0]      r_miss_cnt, w_miss_cnt_nxt;

  logic [NB_DATA-1:0]       r_data;
  logic                     r_valid;
  logic                     r_sop;
  logic                     r_lock;

  logic                     w_size_ok;
  logic                     w_boundary;
  logic [NB_FRAME_SIZE-1:0] w_word_wrap;
  logic [c_hit_w-1:0]       w_hit_inc;
  logic [c_miss_w-1:0]      w_miss_inc;
  logic                     w_sop;

  // Frames shorter than two words can never be aligned.
  assign w_size_ok   = (i_frame_size >= NB_FRAME_SIZE'(2));
  assign w_boundary  = (r_word_cnt == '0);
  assign w_word_wrap = (r_word_cnt == (i_frame_size - NB_FRAME_SIZE'(1)))
                       ? '0 : (r_word_cnt + NB_FRAME_SIZE'(1));
  assign w_hit_inc   = r_hit_cnt + c_hit_w'(1);
  assign w_miss_inc  = r_miss_cnt + c_miss_w'(1);

  // Next-state logic: only valid words move the FSM and counters.
  always_comb begin
    w_state_nxt    = r_state;
    w_word_cnt_nxt = r_word_cnt;
    w_hit_cnt_nxt  = r_hit_cnt;
    w_miss_cnt_nxt = r_miss_cnt;
    if (i_valid) begin
      if (!w_size_ok) begin
        w_state_nxt    = c_hunt;
        w_word_cnt_nxt = '0;
        w_hit_cnt_nxt  = '0;
        w_miss_cnt_nxt = '0;
      end else begin
        case (r_state)
          c_hunt: begin
            w_word_cnt_nxt = '0;
            if (w_hit) begin
              // The FAS word itself is word 0 of the candidate frame.
              w_state_nxt    = c_presync;
              w_word_cnt_nxt = NB_FRAME_SIZE'(1);
              w_hit_cnt_nxt  = '0;
            end
          end
          c_presync: begin
            w_word_cnt_nxt = w_word_wrap;
            if (w_boundary) begin
              if (w_hit) begin
                w_hit_cnt_nxt = w_hit_inc;
                if (w_hit_inc == c_hit_w'(N_CONFIRM)) begin
                  w_state_nxt    = c_sync;
                  w_miss_cnt_nxt = '0;
                end
              end else begin
                w_state_nxt    = c_hunt;
                w_word_cnt_nxt = '0;
              end
            end
          end
          c_sync: begin
            w_word_cnt_nxt = w_word_wrap;
            if (w_boundary) begin
              if (w_hit) begin
                w_miss_cnt_nxt = '0;
              end else begin
                w_miss_cnt_nxt = w_miss_inc;
                if (w_miss_inc == c_miss_w'(N_LOSS)) begin
                  w_state_nxt    = c_hunt;
                  w_word_cnt_nxt = '0;
                  w_miss_cnt_nxt = '0;
                end
              end
            end
          end
          default: begin
            w_state_nxt    = c_hunt;
            w_word_cnt_nxt = '0;
            w_hit_cnt_nxt  = '0;
            w_miss_cnt_nxt = '0;
          end
        endcase
      end
    end
  end

  // SOP marks a frame's first word whenever the word leaves us locked,
  // so the locking word counts and the lock-dropping word does not.
  assign w_sop = i_valid && w_boundary && (w_state_nxt == c_sync);

  // State, counters and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= c_hunt;
      r_word_cnt <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_sop      <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_hit_cnt  <= w_hit_cnt_nxt;
      r_miss_cnt <= w_miss_cnt_nxt;
      if (i_valid) begin
        r_data <= i_data;
      end
      r_valid    <= i_valid;
      r_sop      <= w_sop;
      r_lock     <= (w_state_nxt == c_sync);
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_sop   = r_sop;
  assign o_lock  = r_lock;

`ifdef GCM_FRAME_ALIGNER_FAS_ERR_CNT_EN
  logic        w_sync_miss;
  logic [15:0] r_fas_err_count;

  assign w_sync_miss = i_valid && w_size_ok && (r_state == c_sync)
                       && w_boundary && !w_hit;

  // Saturating count of FAS misses while locked; only reset clears it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_fas_err_count <= '0;
    end else if (w_sync_miss && (r_fas_err_count != 16'hFFFF)) begin
      r_fas_err_count <= r_fas_err_count + 16'd1;
    end
  end

  assign o_fas_err_count = r_fas_err_count;
`else
  assign o_fas_err_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gcm_frame_aligner.sv
// ============================================================================
//  Module      : tb_gcm_frame_aligner
//  Description : Self-checking bench for gcm_frame_aligner. A frame generator
//                drives FAS-headed frames with random payload, random valid
//                gaps, corrupted and false FAS words and mid-frame resets; a
//                behavioural model predicts every output cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcm_frame_aligner;

  localparam int          NB_DATA       = 256;
  localparam int          NB_FRAME_SIZE = 16;
  localparam int          NB_FAS        = 48;
  localparam int          N_CONFIRM     = 2;
  localparam int          N_LOSS        = 3;
  localparam logic [47:0] c_fas_pat     = 48'hf6f6f6282828;

  logic                     tb_i_clock;
  logic                     tb_i_reset;
  logic [NB_DATA-1:0]       tb_i_data;
  logic                     tb_i_valid;
  logic [NB_FRAME_SIZE-1:0] tb_i_frame_size;
  logic [NB_DATA-1:0]       tb_i_fas;
  logic [NB_DATA-1:0]       tb_o_data;
  logic                     tb_o_valid;
  logic                     tb_o_sop;
  logic                     tb_o_lock;
  logic [15:0]              tb_o_fas_err_count;

  gcm_frame_aligner #(
    .NB_DATA       (NB_DATA),
    .NB_FRAME_SIZE (NB_FRAME_SIZE),
    .NB_FAS        (NB_FAS),
    .MSB_IS_NEWER  (0),
    .N_CONFIRM     (N_CONFIRM),
    .N_LOSS        (N_LOSS)
  ) dut (
    .i_clock         (tb_i_clock),
    .i_reset         (tb_i_reset),
    .i_data          (tb_i_data),
    .i_valid         (tb_i_valid),
    .i_frame_size    (tb_i_frame_size),
    .i_fas           (tb_i_fas),
    .o_data          (tb_o_data),
    .o_valid         (tb_o_valid),
    .o_sop           (tb_o_sop),
    .o_lock          (tb_o_lock),
    .o_fas_err_count (tb_o_fas_err_count)
  );

  initial tb_i_clock = 1'b0;
  always #5 tb_i_clock = ~tb_i_clock;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: alignment is described by an anchor position and
  // modular distance from it rather than by a wrapping word counter.
  bit                 m_tracking;
  bit                 m_locked;
  int                 m_anchor;
  int                 m_confirms;
  int                 m_misses;
  int                 m_vidx = 0;
  int                 m_err;
  logic [NB_DATA-1:0] e_data;
  logic               e_valid;
  logic               e_sop;
  logic               e_lock;
  logic [15:0]        e_err;

  // Frame generator state.
  int frame_len;
  int gen_pos;
  bit corrupt_fr [0:63];
  int false_fr;
  int false_off;
  int rst_at;

  task automatic check_eq(input string tag, input logic [255:0] obs,
                          input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] err_view(input int n);
`ifdef GCM_FRAME_ALIGNER_FAS_ERR_CNT_EN
    return (n > 65535) ? 16'hFFFF : n[15:0];
`else
    return (n > 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  function automatic logic [NB_DATA-1:0] rand_word();
    logic [NB_DATA-1:0] w;
    for (int i = 0; i < NB_DATA / 32; i++) w[i*32 +: 32] = $urandom;
    if (w[NB_DATA-1 -: NB_FAS] == c_fas_pat) w[NB_DATA-1] = ~w[NB_DATA-1];
    return w;
  endfunction

  function automatic logic [NB_DATA-1:0] fas_word();
    logic [NB_DATA-1:0] w;
    w = rand_word();
    w[NB_DATA-1 -: NB_FAS] = c_fas_pat;
    return w;
  endfunction

  task automatic model_update(input logic [NB_DATA-1:0] d, input logic v,
                              input logic r);
    bit hit;
    int f;
    if (r) begin
      m_tracking = 0; m_locked = 0; m_err = 0;
      e_data = '0; e_valid = 0; e_sop = 0; e_lock = 0; e_err = '0;
      return;
    end
    e_valid = v;
    e_sop   = 0;
    if (!v) return;
    e_data = d;
    hit    = (d[NB_DATA-1 -: NB_FAS] == c_fas_pat);
    f      = frame_len;
    if (f < 2) begin
      m_tracking = 0;
      m_locked   = 0;
    end else if (!m_tracking && !m_locked) begin
      if (hit) begin
        m_tracking = 1; m_anchor = m_vidx; m_confirms = 0;
      end
    end else if (((m_vidx - m_anchor) % f) == 0) begin
      if (!m_locked) begin
        if (hit) begin
          m_confirms++;
          if (m_confirms == N_CONFIRM) begin
            m_locked = 1; m_tracking = 0; m_misses = 0;
          end
        end else begin
          m_tracking = 0;
        end
      end else begin
        if (hit) m_misses = 0;
        else begin
          m_misses++;
          m_err++;
          if (m_misses == N_LOSS) m_locked = 0;
        end
      end
      e_sop = m_locked;
    end
    e_lock = m_locked;
    e_err  = err_view(m_err);
    m_vidx++;
  endtask

  task automatic step(input logic [NB_DATA-1:0] d, input logic v, input logic r);
    @(negedge tb_i_clock);
    tb_i_data  = d;
    tb_i_valid = v;
    tb_i_reset = r;
    model_update(d, v, r);
    @(posedge tb_i_clock);
    #1;
    check_eq("o_data",  tb_o_data,          e_data);
    check_eq("o_valid", tb_o_valid,         e_valid);
    check_eq("o_sop",   tb_o_sop,           e_sop);
    check_eq("o_lock",  tb_o_lock,          e_lock);
    check_eq("o_err",   tb_o_fas_err_count, e_err);
  endtask

  task automatic send_words(input int n, input int pct);
    logic [NB_DATA-1:0] w;
    logic               v;
    int                 fr;
    int                 off;
    for (int c = 0; c < n; c++) begin
      if (rst_at >= 0 && gen_pos == rst_at) begin
        step(rand_word(), 1'b1, 1'b1);
        step(rand_word(), 1'b1, 1'b1);
        rst_at = -1;
      end
      v = ($urandom_range(99) < pct);
      if (v) begin
        fr  = gen_pos / frame_len;
        off = gen_pos % frame_len;
        if (off == 0) begin
          w = fas_word();
          if (fr < 64 && corrupt_fr[fr])
            w[NB_DATA - NB_FAS + $urandom_range(NB_FAS-1)] ^= 1'b1;
        end else if (fr == false_fr && off == false_off) begin
          w = fas_word();
        end else begin
          w = rand_word();
        end
        gen_pos++;
      end else begin
        w = rand_word();
      end
      step(w, v, 1'b0);
    end
  endtask

  task automatic start_scenario(input int f);
    frame_len       = f;
    tb_i_frame_size = NB_FRAME_SIZE'(f);
    for (int i = 0; i < 64; i++) corrupt_fr[i] = 0;
    false_fr  = -1;
    false_off = -1;
    rst_at    = -1;
    gen_pos   = 0;
    step(rand_word(), 1'b1, 1'b1);
    step(rand_word(), 1'b1, 1'b1);
  endtask

  initial begin
    tb_i_reset      = 1'b1;
    tb_i_valid      = 1'b0;
    tb_i_data       = '0;
    tb_i_frame_size = 16'd510;
    tb_i_fas        = {c_fas_pat, 208'd0};

    // Reset state, then clean continuous lock with F=510.
    start_scenario(510);
    check_eq("rst_data", tb_o_data, 256'd0);
    check_eq("rst_lock", {tb_o_valid, tb_o_sop, tb_o_lock}, 3'b000);
    send_words(1020, 100);
    check_eq("clean_prelock", tb_o_lock, 1'b0);
    send_words(1, 100);
    check_eq("clean_lock", tb_o_lock, 1'b1);
    check_eq("clean_sop",  tb_o_sop,  1'b1);
    send_words(1100, 100);

    // Random null-valid gaps.
    start_scenario(510);
    send_words(5000, 60);
    check_eq("gaps_lock", tb_o_lock, 1'b1);

    // FAS corruption while locked, then relock.
    start_scenario(64);
    corrupt_fr[4] = 1;
    corrupt_fr[6] = 1;
    corrupt_fr[7] = 1;
    corrupt_fr[8] = 1;
    send_words(257, 100);
    check_eq("corr1_lock", tb_o_lock, 1'b1);
    check_eq("corr1_err",  tb_o_fas_err_count, err_view(1));
    send_words(256, 100);
    check_eq("corr3_lock", tb_o_lock, 1'b0);
    check_eq("corr3_err",  tb_o_fas_err_count, err_view(4));
    send_words(191, 100);
    check_eq("relock_pre", tb_o_lock, 1'b0);
    send_words(1, 100);
    check_eq("relock",     tb_o_lock, 1'b1);
    send_words(70, 100);

    // False FAS in HUNT ahead of the real sequence.
    start_scenario(510);
    corrupt_fr[0] = 1;
    false_fr  = 0;
    false_off = 100;
    send_words(611, 100);
    check_eq("false_nolock", tb_o_lock, 1'b0);
    send_words(1429, 100);
    check_eq("false_prelock", tb_o_lock, 1'b0);
    send_words(1, 100);
    check_eq("false_lock", tb_o_lock, 1'b1);

    // Reset in the middle of a locked frame.
    start_scenario(64);
    rst_at = 3 * 64 + 30;
    send_words(900, 80);
    check_eq("rst_relock", tb_o_lock, 1'b1);

    // Degenerate frame size: never locks.
    start_scenario(1);
    send_words(5000, 100);
    check_eq("deg_lock", tb_o_lock, 1'b0);
    check_eq("deg_sop",  tb_o_sop,  1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
